// File: rtl/sap1_controller_sequencer.sv
// rtl/sap1_controller_sequencer.sv - SAP-1 T-state ring counter and instruction decoder
module sap1_controller_sequencer #(
    parameter int                    OPCODE_WIDTH = 4,
    parameter logic [OPCODE_WIDTH-1:0] OP_LDA     = 4'b0000,
    parameter logic [OPCODE_WIDTH-1:0] OP_ADD     = 4'b0001,
    parameter logic [OPCODE_WIDTH-1:0] OP_SUB     = 4'b0010,
    parameter logic [OPCODE_WIDTH-1:0] OP_OUT     = 4'b1110,
    parameter logic [OPCODE_WIDTH-1:0] OP_HLT     = 4'b1111
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [OPCODE_WIDTH-1:0] opcode,
    output logic [11:0]             con,
    output logic [5:0]              t_state,
    output logic                    halt
);

    // Control word bit order: {cp, ep, lm_n, ce_n, li_n, ei_n, la_n, ea, su, eu, lb_n, lo_n}
    localparam logic [11:0] CON_IDLE = 12'h3E3;

    typedef enum logic [2:0] {
        ST_T1, ST_T2, ST_T3, ST_T4, ST_T5, ST_T6, ST_HALT
    } state_t;

    state_t state;

    // Falling-edge sequencing keeps the control word settled before the datapath's rising edge.
    always_ff @(negedge clk or posedge reset) begin
        if (reset) begin
            state   <= ST_T1;
            t_state <= 6'b000001;
            halt    <= 1'b0;
        end else begin
            case (state)
                ST_T1: begin
                    state   <= ST_T2;
                    t_state <= 6'b000010;
                end
                ST_T2: begin
                    state   <= ST_T3;
                    t_state <= 6'b000100;
                end
                ST_T3: begin
                    state   <= ST_T4;
                    t_state <= 6'b001000;
                end
                ST_T4: begin
                    if (opcode == OP_HLT) begin
                        state   <= ST_HALT;
                        t_state <= 6'b000000;
                        halt    <= 1'b1;
                    end else begin
                        state   <= ST_T5;
                        t_state <= 6'b010000;
                    end
                end
                ST_T5: begin
                    state   <= ST_T6;
                    t_state <= 6'b100000;
                end
                ST_T6: begin
                    state   <= ST_T1;
                    t_state <= 6'b000001;
                end
                ST_HALT: begin
                    state   <= ST_HALT;
                    t_state <= 6'b000000;
                    halt    <= 1'b1;
                end
                default: begin
                    state   <= ST_T1;
                    t_state <= 6'b000001;
                    halt    <= 1'b0;
                end
            endcase
        end
    end

    // Fetch words ignore opcode; only T4-T6 decode it.
    always_comb begin
        con = CON_IDLE;
        if (!halt) begin
            if (t_state[0]) begin
                con = 12'h5E3;
            end else if (t_state[1]) begin
                con = 12'hBE3;
            end else if (t_state[2]) begin
                con = 12'h263;
            end else if (t_state[3]) begin
                case (opcode)
                    OP_LDA, OP_ADD, OP_SUB: con = 12'h1A3;
                    OP_OUT:                 con = 12'h3F2;
                    default:                con = CON_IDLE;
                endcase
            end else if (t_state[4]) begin
                case (opcode)
                    OP_LDA:         con = 12'h2C3;
                    OP_ADD, OP_SUB: con = 12'h2E1;
                    default:        con = CON_IDLE;
                endcase
            end else if (t_state[5]) begin
                case (opcode)
                    OP_ADD:  con = 12'h3C7;
                    OP_SUB:  con = 12'h3CF;
                    default: con = CON_IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_sap1_controller_sequencer.sv
// tb/tb_sap1_controller_sequencer.sv - self-checking bench for the SAP-1 controller/sequencer
module tb_sap1_controller_sequencer;

    logic        clk = 1'b1;
    logic        reset = 1'b0;
    logic [3:0]  opcode = 4'b0000;
    logic [11:0] con;
    logic [5:0]  t_state;
    logic        halt;

    int checks = 0;
    int passed = 0;

    sap1_controller_sequencer dut (
        .clk     (clk),
        .reset   (reset),
        .opcode  (opcode),
        .con     (con),
        .t_state (t_state),
        .halt    (halt)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got === exp) passed++;
        else $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    endtask

    function automatic int bus_drivers(input logic [11:0] w);
        return int'(w[10]) + int'(!w[8]) + int'(!w[6]) + int'(w[4]) + int'(w[2]);
    endfunction

    // Reference control word for T-state number step (0 = T1) of an instruction with opcode op.
    function automatic logic [11:0] exp_word(input int step, input logic [3:0] op);
        logic [11:0] fetch [3];
        logic [11:0] exec  [3];
        fetch[0] = 12'h5E3; fetch[1] = 12'hBE3; fetch[2] = 12'h263;
        case (op)
            4'b0000: begin exec[0] = 12'h1A3; exec[1] = 12'h2C3; exec[2] = 12'h3E3; end
            4'b0001: begin exec[0] = 12'h1A3; exec[1] = 12'h2E1; exec[2] = 12'h3C7; end
            4'b0010: begin exec[0] = 12'h1A3; exec[1] = 12'h2E1; exec[2] = 12'h3CF; end
            4'b1110: begin exec[0] = 12'h3F2; exec[1] = 12'h3E3; exec[2] = 12'h3E3; end
            default: begin exec[0] = 12'h3E3; exec[1] = 12'h3E3; exec[2] = 12'h3E3; end
        endcase
        return (step < 3) ? fetch[step] : exec[step-3];
    endfunction

    task automatic check_state(input string tag, input logic [5:0] ts, input logic [11:0] w,
                               input logic h);
        check_eq({tag, "_tstate"}, 32'(t_state), 32'(ts));
        check_eq({tag, "_con"},    32'(con),     32'(w));
        check_eq({tag, "_halt"},   32'(halt),    32'(h));
        check_eq({tag, "_bus"},    32'(bus_drivers(con) <= 1), 32'd1);
    endtask

    // Assert reset wherever we are, then release it during clock-low just after a falling edge.
    task automatic do_reset(input string tag);
        reset = 1'b1;
        #1;
        check_state({tag, "_rst"}, 6'b000001, 12'h5E3, 1'b0);
        @(negedge clk);
        #1;
        check_state({tag, "_rsthold"}, 6'b000001, 12'h5E3, 1'b0);
        reset = 1'b0;
        #1;
    endtask

    // Starts just after a falling edge in T1; opcode is scrambled during fetch.
    task automatic run_instr(input string tag, input logic [3:0] op);
        for (int s = 0; s < 6; s++) begin
            opcode = (s < 3) ? 4'($urandom_range(0, 15)) : op;
            @(posedge clk);
            check_state($sformatf("%s_T%0d", tag, s + 1), 6'(1 << s), exp_word(s, op), 1'b0);
            if (s == 3 && op == 4'b1111) begin
                @(negedge clk);
                #1;
                check_state({tag, "_halted"}, 6'b000000, 12'h3E3, 1'b1);
                return;
            end
            @(negedge clk);
            #1;
        end
    endtask

    task automatic hold_halted(input string tag, input int n);
        for (int i = 0; i < n; i++) begin
            opcode = 4'($urandom_range(0, 15));
            @(posedge clk);
            check_state($sformatf("%s_%0d", tag, i), 6'b000000, 12'h3E3, 1'b1);
            @(negedge clk);
            #1;
        end
    endtask

    initial begin
        logic [3:0] op;
        #2;
        do_reset("init");

        // Reset pulse in the middle of T3
        opcode = 4'b0001;
        @(posedge clk); @(negedge clk); #1;
        @(posedge clk); @(negedge clk); #1;
        @(posedge clk); #2;
        check_eq("midT3_tstate", 32'(t_state), 32'(6'b000100));
        do_reset("midT3");
        run_instr("after_rst", 4'b0000);

        run_instr("lda", 4'b0000);
        check_eq("lda_wrap", 32'(t_state), 32'(6'b000001));
        run_instr("add", 4'b0001);
        run_instr("sub", 4'b0010);
        run_instr("out", 4'b1110);
        run_instr("undef", 4'b0111);
        run_instr("hlt", 4'b1111);
        hold_halted("hold", 20);
        do_reset("unhalt");
        run_instr("post_hlt", 4'b0000);

        for (int i = 0; i < 200; i++) begin
            op = 4'($urandom_range(0, 15));
            run_instr($sformatf("rnd%0d", i), op);
            if (op == 4'b1111) begin
                hold_halted($sformatf("rnd%0d_hold", i), 3);
                do_reset($sformatf("rnd%0d", i));
            end
        end

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
